// File: rtl/st7735_pkg.sv
// Shared definitions for the st7735 pixel datapath: panel geometry, coordinate widths,
// RGB565 constants and the frame sequencer state encoding.
package st7735_pkg;

    localparam int unsigned LCD_WIDTH  = 160;
    localparam int unsigned LCD_HEIGHT = 80;

    localparam int unsigned X_W     = 8;
    localparam int unsigned Y_W     = 7;
    localparam int unsigned PAT_W   = 2;
    localparam int unsigned COLOR_W = 16;

    localparam logic [COLOR_W-1:0] RGB_GREEN   = 16'h07E0;
    localparam logic [COLOR_W-1:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [COLOR_W-1:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [COLOR_W-1:0] RGB_BLUE    = 16'h001F;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } seq_state_e;

    // Next pattern in the rotation, wrapping after the last configured pattern.
    function automatic logic [PAT_W-1:0] next_pat(input logic [PAT_W-1:0] cur,
                                                   input int unsigned     num_pat);
        return (32'(cur) == (num_pat - 1)) ? '0 : cur + PAT_W'(1);
    endfunction

endpackage

// File: rtl/st7735_frame_detect.sv
// Frame boundary detector: registers the scan coordinates and pulses frame_tick once when
// the raster leaves the last visible pixel.
module st7735_frame_detect
    import st7735_pkg::*;
#(
    parameter int unsigned WIDTH  = LCD_WIDTH,
    parameter int unsigned HEIGHT = LCD_HEIGHT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    output logic           frame_tick
);

    localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

    logic [X_W-1:0] px;
    logic [Y_W-1:0] py;
    logic           at_last_c;
    logic           moved_c;

    // Holding the last pixel never ticks; any departure from it ticks exactly once.
    assign at_last_c = (px == X_LAST) && (py == Y_LAST);
    assign moved_c   = (x != px) || (y != py);

    always_ff @(posedge clk) begin
        if (rst) begin
            px         <= '0;
            py         <= '0;
            frame_tick <= 1'b0;
        end else begin
            px         <= x;
            py         <= y;
            frame_tick <= at_last_c && moved_c;
        end
    end

endmodule

// File: rtl/st7735_frame_sequencer.sv
// Frame-level scheduler for the st7735 datapath: owns pattern index and scroll offset,
// updates them only at frame boundaries, and supplies the pixel color to the driver.
module st7735_frame_sequencer
    import st7735_pkg::*;
#(
    parameter int unsigned WIDTH       = LCD_WIDTH,
    parameter int unsigned HEIGHT      = LCD_HEIGHT,
    parameter int unsigned DWELL       = 60,
    parameter int unsigned NUM_PAT     = 4,
    parameter int unsigned SCROLL_STEP = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [X_W-1:0]     x,
    input  logic [Y_W-1:0]     y,
    input  logic               pause_tgl,
    input  logic               step,
    output logic [COLOR_W-1:0] color,
    output logic [PAT_W-1:0]   pat_idx,
    output logic               frame_tick,
    output logic               paused_led,
    output logic               frame_led
);

    localparam int unsigned        DWELL_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
    localparam logic [7:0]         SCROLL_INC = 8'(SCROLL_STEP);

    seq_state_e         state;
    logic [7:0]         scroll;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               step_pend;
    logic [7:0]         xs_c;

    st7735_frame_detect #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT)
    ) u_detect (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .y         (y),
        .frame_tick(frame_tick)
    );

    // Boundary updates use the state before any same-cycle toggle takes effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            pat_idx    <= '0;
            scroll     <= '0;
            dwell_cnt  <= '0;
            step_pend  <= 1'b0;
            paused_led <= 1'b0;
            frame_led  <= 1'b0;
        end else begin
            if (frame_tick) begin
                frame_led <= ~frame_led;
                if (state == ST_RUN) begin
                    scroll <= scroll + SCROLL_INC;
                    if (dwell_cnt == DWELL_LAST) begin
                        dwell_cnt <= '0;
                        pat_idx   <= next_pat(pat_idx, NUM_PAT);
                    end else begin
                        dwell_cnt <= dwell_cnt + DWELL_W'(1);
                    end
                end else if (step_pend || step) begin
                    pat_idx   <= next_pat(pat_idx, NUM_PAT);
                    dwell_cnt <= '0;
                end
            end

            if (state == ST_RUN) begin
                if (pause_tgl) begin
                    state      <= ST_PAUSE;
                    paused_led <= 1'b1;
                end
            end else begin
                if (pause_tgl) begin
                    state      <= ST_RUN;
                    paused_led <= 1'b0;
                    step_pend  <= 1'b0;
                end else if (frame_tick) begin
                    step_pend <= 1'b0;
                end else if (step) begin
                    step_pend <= 1'b1;
                end
            end
        end
    end

    // Zero-latency pattern generator evaluated at the driver's current coordinate.
    always_comb begin
        xs_c  = x + scroll;
        color = RGB_MAGENTA;
        case (pat_idx)
            2'd0:    color = (xs_c[3] ^ y[3]) ? RGB_GREEN : RGB_MAGENTA;
            2'd1:    color = {xs_c[7:5], 2'b00, 6'd0, xs_c[4:0]};
            2'd2:    color = {y[6:2], 6'd0, 5'd0};
            default: color = scroll[7] ? RGB_WHITE : RGB_BLUE;
        endcase
    end

endmodule
